// File: rtl/dot_out_serializer_if.sv
// rtl/dot_out_serializer_if.sv - vector-in / beat-out handshake bundle for dot_out_serializer
interface dot_out_serializer_if #(
    parameter int BIT_LENGTH = 16,
    parameter int HID_LENGTH = 24,
    parameter int DATA_N     = 6
);
    localparam int BEATS = (HID_LENGTH + DATA_N - 1) / DATA_N;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                             in_valid;
    logic [HID_LENGTH*BIT_LENGTH-1:0] in_data;
    logic                             in_ready;
    logic                             out_valid;
    logic                             out_ready;
    logic [DATA_N*BIT_LENGTH-1:0]     out_data;
    logic [IDX_W-1:0]                 out_idx;
    logic                             out_last;
    logic                             overflow;

    // master: the engine/downstream side; slave: the serializer itself
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, overflow
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, overflow
    );
endinterface

// File: rtl/dot_out_serializer.sv
// rtl/dot_out_serializer.sv - captures a wide result vector and replays it as DATA_N-lane beats
module dot_out_serializer #(
    parameter int BIT_LENGTH = 16,
    parameter int HID_LENGTH = 24,
    parameter int DATA_N     = 6
) (
    input  logic                clk,
    input  logic                rst,
    dot_out_serializer_if.slave bus
);
    localparam int BEATS = (HID_LENGTH + DATA_N - 1) / DATA_N;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                           state;
    logic [IDX_W-1:0]                 idx;
    logic [HID_LENGTH*BIT_LENGTH-1:0] vec_buf;
    logic                             ovf_q;
    logic                             at_last;

    assign at_last       = (state == SEND) && (idx == LAST_IDX);
    assign bus.out_valid = (state == SEND);
    assign bus.out_idx   = idx;
    assign bus.out_last  = at_last;
    assign bus.overflow  = ovf_q;
    // The last-beat handshake frees the buffer in the same cycle, so a new vector can land without a gap.
    assign bus.in_ready  = (state == IDLE) || (at_last && bus.out_ready);

    // Lanes past the end of the vector read as zero padding.
    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < DATA_N; i++) begin
            if (int'(idx) * DATA_N + i < HID_LENGTH)
                bus.out_data[i*BIT_LENGTH +: BIT_LENGTH] =
                    vec_buf[(int'(idx) * DATA_N + i) * BIT_LENGTH +: BIT_LENGTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            vec_buf <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (bus.in_valid && !bus.in_ready)
                ovf_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        vec_buf <= bus.in_data;
                        idx     <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        if (idx != LAST_IDX) begin
                            idx <= idx + IDX_W'(1);
                        end else if (bus.in_valid) begin
                            vec_buf <= bus.in_data;
                            idx     <= '0;
                        end else begin
                            idx   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dot_out_serializer.sv
// tb/tb_dot_out_serializer.sv - randomized and directed checks of dot_out_serializer against a beat-queue model
module tb_dot_out_serializer;
    localparam int BL    = 16;
    localparam int HL    = 24;
    localparam int DN    = 6;
    localparam int BEATS = 4;
    localparam int W     = HL * BL;
    localparam int DW    = DN * BL;
    localparam int PHL   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dot_out_serializer_if #(.BIT_LENGTH(BL), .HID_LENGTH(HL), .DATA_N(DN)) m ();
    dot_out_serializer_if #(.BIT_LENGTH(BL), .HID_LENGTH(PHL), .DATA_N(DN)) p ();

    dot_out_serializer #(.BIT_LENGTH(BL), .HID_LENGTH(HL), .DATA_N(DN)) dut (
        .clk(clk), .rst(rst), .bus(m.slave));
    dot_out_serializer #(.BIT_LENGTH(BL), .HID_LENGTH(PHL), .DATA_N(DN)) dut_pad (
        .clk(clk), .rst(rst), .bus(p.slave));

    typedef struct {
        logic [DW-1:0] data;
        int            idx;
    } beat_t;

    beat_t q[$];
    logic  exp_ovf;
    int    checks   = 0;
    int    failures = 0;

    logic [DW-1:0] obs_data;
    logic          obs_valid, obs_ready, obs_last, obs_ovf;
    int            obs_idx;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BL-1:0] lane(input logic [DW-1:0] d, input int i);
        return d[i*BL +: BL];
    endfunction

    function automatic logic [W-1:0] vec_fill(input int v);
        logic [W-1:0] r;
        for (int e = 0; e < HL; e++) r[e*BL +: BL] = BL'(v);
        return r;
    endfunction

    function automatic logic [W-1:0] vec_ramp();
        logic [W-1:0] r;
        for (int e = 0; e < HL; e++) r[e*BL +: BL] = BL'(e + 1);
        return r;
    endfunction

    function automatic logic [W-1:0] vec_rand();
        logic [W-1:0] r;
        for (int e = 0; e < HL; e++) r[e*BL +: BL] = BL'($urandom);
        return r;
    endfunction

    task automatic push_vector(input logic [W-1:0] v);
        beat_t b;
        for (int k = 0; k < BEATS; k++) begin
            b.idx  = k;
            b.data = '0;
            for (int i = 0; i < DN; i++)
                if (k * DN + i < HL) b.data[i*BL +: BL] = v[(k*DN + i)*BL +: BL];
            q.push_back(b);
        end
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model at the rising edge.
    task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy);
        logic exp_ir;
        m.in_valid  = iv;
        m.in_data   = d;
        m.out_ready = ordy;
        @(negedge clk);
        exp_ir    = (q.size() == 0) || (q.size() == 1 && ordy);
        obs_data  = m.out_data;
        obs_valid = m.out_valid;
        obs_ready = m.in_ready;
        obs_last  = m.out_last;
        obs_ovf   = m.overflow;
        obs_idx   = int'(m.out_idx);
        chk("out_valid", 128'(obs_valid), 128'(q.size() != 0));
        chk("in_ready", 128'(obs_ready), 128'(exp_ir));
        chk("overflow", 128'(obs_ovf), 128'(exp_ovf));
        if (q.size() != 0) begin
            chk("out_data", 128'(obs_data), 128'(q[0].data));
            chk("out_idx", 128'(obs_idx), 128'(q[0].idx));
            chk("out_last", 128'(obs_last), 128'(q[0].idx == BEATS - 1));
        end
        @(posedge clk);
        if (q.size() != 0 && ordy) void'(q.pop_front());
        if (iv) begin
            if (exp_ir) push_vector(d);
            else exp_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 128'(m.out_valid), 128'(0));
        chk({tag, "_out_data"}, 128'(m.out_data), 128'(0));
        chk({tag, "_out_idx"}, 128'(m.out_idx), 128'(0));
        chk({tag, "_out_last"}, 128'(m.out_last), 128'(0));
        chk({tag, "_overflow"}, 128'(m.overflow), 128'(0));
        chk({tag, "_in_ready"}, 128'(m.in_ready), 128'(1));
    endtask

    initial begin
        logic [W-1:0]  a;
        logic [DW-1:0] pad_exp;
        exp_ovf     = 1'b0;
        m.in_valid  = 1'b1;
        m.in_data   = vec_ramp();
        m.out_ready = 1'b1;
        p.in_valid  = 1'b0;
        p.in_data   = '0;
        p.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_init");
        @(negedge clk);
        rst = 1'b0;
        m.in_valid = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b0, '0, 1'b1);

        // single vector, elements 1..24
        cycle(1'b1, vec_ramp(), 1'b1);
        cycle(1'b0, '0, 1'b1);
        chk("single_b0_lane0", 128'(lane(obs_data, 0)), 128'(1));
        chk("single_b0_lane5", 128'(lane(obs_data, 5)), 128'(6));
        chk("single_b0_idx", 128'(obs_idx), 128'(0));
        chk("single_b0_last", 128'(obs_last), 128'(0));
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < DN; i++)
            chk("single_b3_lane", 128'(lane(obs_data, i)), 128'(19 + i));
        chk("single_b3_last", 128'(obs_last), 128'(1));
        cycle(1'b0, '0, 1'b1);
        chk("single_idle", 128'(obs_valid), 128'(0));

        // backpressure on beat 1
        cycle(1'b1, vec_ramp(), 1'b1);
        cycle(1'b0, '0, 1'b1);
        for (int s = 0; s < 3; s++) begin
            cycle(1'b0, '0, 1'b0);
            chk("bp_hold_lane0", 128'(lane(obs_data, 0)), 128'(7));
            chk("bp_hold_idx", 128'(obs_idx), 128'(1));
        end
        cycle(1'b0, '0, 1'b1);
        chk("bp_b1_lane5", 128'(lane(obs_data, 5)), 128'(12));
        cycle(1'b0, '0, 1'b1);
        chk("bp_b2_lane0", 128'(lane(obs_data, 0)), 128'(13));
        cycle(1'b0, '0, 1'b1);
        chk("bp_b3_lane5", 128'(lane(obs_data, 5)), 128'(24));

        // back-to-back: B offered on A's last-beat handshake
        cycle(1'b1, vec_fill(5), 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, vec_fill(9), 1'b1);
        chk("b2b_in_ready", 128'(obs_ready), 128'(1));
        chk("b2b_a_last", 128'(lane(obs_data, 3)), 128'(5));
        cycle(1'b0, '0, 1'b1);
        chk("b2b_b0_valid", 128'(obs_valid), 128'(1));
        chk("b2b_b0_lane0", 128'(lane(obs_data, 0)), 128'(9));
        chk("b2b_b0_idx", 128'(obs_idx), 128'(0));
        chk("b2b_overflow", 128'(obs_ovf), 128'(0));
        repeat (3) cycle(1'b0, '0, 1'b1);

        // overflow: C offered during A's beat 1
        cycle(1'b1, vec_fill(5), 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, vec_fill(7), 1'b1);
        chk("ovf_in_ready", 128'(obs_ready), 128'(0));
        for (int k = 2; k < BEATS; k++) begin
            cycle(1'b0, '0, 1'b1);
            chk("ovf_sticky", 128'(obs_ovf), 128'(1));
            chk("ovf_a_intact", 128'(lane(obs_data, 2)), 128'(5));
        end
        cycle(1'b0, '0, 1'b1);
        chk("ovf_c_dropped", 128'(obs_valid), 128'(0));

        // asynchronous reset in the middle of a vector, with a vector offered
        cycle(1'b1, vec_ramp(), 1'b1);
        m.in_valid  = 1'b1;
        m.in_data   = vec_fill(3);
        m.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        q.delete();
        exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        rst = 1'b0;
        cycle(1'b0, '0, 1'b1);
        chk("rst_no_capture", 128'(obs_valid), 128'(0));

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            a = vec_rand();
            cycle(($urandom_range(0, 4) == 0), a, ($urandom_range(0, 9) < 7));
        end
        while (q.size() != 0) cycle(1'b0, '0, 1'b1);

        // padding build: 8 elements over 6 lanes
        for (int e = 0; e < PHL; e++) p.in_data[e*BL +: BL] = BL'(e + 1);
        p.in_valid = 1'b1;
        @(posedge clk);
        #1;
        p.in_valid = 1'b0;
        @(negedge clk);
        chk("pad_b0_valid", 128'(p.out_valid), 128'(1));
        chk("pad_b0_data", 128'(p.out_data), 128'({16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}));
        chk("pad_b0_last", 128'(p.out_last), 128'(0));
        @(negedge clk);
        pad_exp = {16'd0, 16'd0, 16'd0, 16'd0, 16'd8, 16'd7};
        chk("pad_b1_data", 128'(p.out_data), 128'(pad_exp));
        chk("pad_b1_idx", 128'(p.out_idx), 128'(1));
        chk("pad_b1_last", 128'(p.out_last), 128'(1));
        @(negedge clk);
        chk("pad_idle", 128'(p.out_valid), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dot_out_serializer.md
# dot_out_serializer

Output-side companion of the 6-lane dot-product engine. The engine presents a full hidden vector of `HID_LENGTH` results on one wide bus when it pulses `valid`. This block captures that vector and transmits it back onto the `DATA_N`-lane, `BIT_LENGTH`-bit bus format the engine itself consumes. It sends one beat per cycle under a valid/ready handshake, so results can be written back or fed to the next layer.

## Interface
- `BIT_LENGTH`, default 16: width of one element.
- `HID_LENGTH`, default 24: elements per captured vector.
- `DATA_N`, default 6: lanes per output beat.
- `BEATS`, derived as ceil(`HID_LENGTH`/`DATA_N`), default 4: beats per vector. Not overridable.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: connects to the engine's `valid`; vector present on `in_data` this cycle.
- `in_data`, in, `HID_LENGTH*BIT_LENGTH`: element e at `[e*BIT_LENGTH +: BIT_LENGTH]`.
- `in_ready`, out, 1: a vector offered this cycle is accepted.
- `out_valid`, out, 1: beat present on `out_data`.
- `out_ready`, in, 1: downstream accepts the beat.
- `out_data`, out, `DATA_N*BIT_LENGTH`: lane i at `[i*BIT_LENGTH +: BIT_LENGTH]`.
- `out_idx`, out, clog2(`BEATS`) (min 1): beat number within the vector.
- `out_last`, out, 1: the current beat is beat `BEATS-1`.
- `overflow`, out, 1: sticky flag; a vector was offered while `in_ready` was low and was dropped.

## Operation
- Holding register: `buf`, `HID_LENGTH*BIT_LENGTH` bits. Beat counter: `idx`.
- States:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - SEND: `out_valid`=1.
- Beat k carries elements k*`DATA_N`+i on lane i. Elements at index ≥ `HID_LENGTH` are driven as zero (padding when `HID_LENGTH` is not a multiple of `DATA_N`).
- Transitions:
  - IDLE → SEND when `in_valid`: capture `in_data` into `buf`, set `idx`=0.
  - SEND: beat handshake when `out_valid & out_ready`. If `idx` < `BEATS-1`, increment `idx`.
  - SEND at the last beat with handshake and `in_valid`: capture the new vector, set `idx`=0, stay in SEND. This gives back-to-back vectors with no gap cycle.
  - SEND at the last beat with handshake and no `in_valid`: go to IDLE.
- `in_ready` is combinational: IDLE, or (SEND & `out_last` & `out_ready`).
- `in_valid & ~in_ready`: the vector is discarded and `overflow` is set. `buf`, `idx`, and state are unchanged. `overflow` clears only on `rst`.
- `out_valid` stalls while `out_ready`=0. `out_data`, `out_idx`, and `out_last` stay stable until the handshake.
- `out_data` is a pure mux of `buf` by `idx`. No arithmetic and no sign handling; bits pass through unchanged.

## Timing
- Reset values: state IDLE, `idx`=0, `buf`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `overflow`=0, `in_ready`=1 (follows from IDLE).
- Latency: vector accepted at edge N → beat 0 valid in the cycle after edge N. With `out_ready` held high, beat `BEATS-1` is valid in the cycle after edge N+`BEATS-1`.
- Throughput: one vector per `BEATS` cycles when `out_ready` stays high.
- The engine's `valid` is a single-cycle pulse with no backpressure. Upstream must space vectors at least `BEATS` cycles apart, or `overflow` records the loss.
- `rst` asserted mid-vector: the remaining beats are abandoned immediately and all outputs take their reset values asynchronously.
- `out_valid` never depends combinationally on `out_ready`.

## Test plan
- **Reset:** assert `rst` mid-cycle with `in_valid`=1 → all outputs 0, `in_ready`=1, no capture.
- **Single vector:** element e = e+1, `out_ready`=1 → four beats on consecutive cycles, `out_idx` 0..3.
  - Beat 0 lanes 0..5 = 1..6; beat 3 lanes = 19..24.
  - `out_last` high only on beat 3.
  - IDLE afterwards.
- **Backpressure:** same vector, `out_ready` low for 3 cycles during beat 1 → beat 1 (lanes 7..12) held stable, then beats 2 and 3 follow; no data lost.
- **Back-to-back:**
  - Stimulus: vector A (all elements 5) accepted, then vector B (all elements 9) offered exactly on the beat-3 handshake cycle.
  - Required response: B accepted (`in_ready`=1), B beat 0 appears in the next cycle with no idle gap, `overflow`=0.
- **Overflow:** offer vector C (all 7) during A's beat 1 → `in_ready`=0, `overflow` rises and stays 1, A transmits intact, C never appears.
- **Padding:** build with `HID_LENGTH`=8, `DATA_N`=6, elements 1..8 → `BEATS`=2; beat 1 lanes = 7, 8, 0, 0, 0, 0.
